// File: rtl/weight_ram_sched_if.sv
// Bundle of the weight RAM controller signals: the sweep control, the read
// and write requesters, and the single-port RAM itself.
// slave = the controller, master = the surrounding logic / RAM.
interface weight_ram_sched_if #(
  parameter int AW = 7,
  parameter int DW = 10
) ();
  logic          init_start;
  logic          busy;
  logic          init_done;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  modport slave (
    input  init_start, rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_q,
    output busy, init_done, rd_ack, rd_valid, rd_data, wr_ack,
           ram_addr, ram_d, ram_we
  );

  modport master (
    output init_start, rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_q,
    input  busy, init_done, rd_ack, rd_valid, rd_data, wr_ack,
           ram_addr, ram_d, ram_we
  );
endinterface

// File: rtl/weight_ram_sched.sv
// Weight RAM scheduler: runs an LFSR-driven initialisation sweep over all
// DEPTH entries on request and, between sweeps, arbitrates the single RAM
// port round-robin between a read and a write requester.
// Optional build macro WRAM_WRITE_CLAMP_EN: saturates requester write data to
// +/-WMAX (sweep data is never clamped).
module weight_ram_sched #(
  parameter int          DEPTH = 65,
  parameter int          AW    = 7,
  parameter int          DW    = 10,
`ifdef WRAM_WRITE_CLAMP_EN
  parameter int          WMAX  = 255,
`endif
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic               Clock,
  input logic               Rst,
  weight_ram_sched_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, INIT = 1'b1} state_t;

  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_A   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] count_r;
  logic [15:0]   lfsr_r;
  logic          last_rd_r;     // 1 = most recent grant went to the reader
  logic          rd_valid_r;
  logic          rd_oob_r;
  logic          init_done_r;
  logic          grant_rd_s, grant_wr_s;
  logic          rd_oob_s, wr_oob_s;
  logic [DW-1:0] wr_value_s;

  // Galois LFSR, right shift, taps 16'hB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] sh;
    sh = {1'b0, v[15:1]};
    if (v[0]) lfsr_step = sh ^ 16'hB400;
    else      lfsr_step = sh;
  endfunction

  // Sign-extend the low 7 LFSR bits into a weight in -64..63.
  function automatic logic [DW-1:0] sext7(input logic [15:0] v);
    sext7 = {{(DW-7){v[6]}}, v[6:0]};
  endfunction

`ifdef WRAM_WRITE_CLAMP_EN
  localparam logic signed [DW-1:0] POS_LIM = DW'(WMAX);
  localparam logic signed [DW-1:0] NEG_LIM = -POS_LIM;

  // Saturate a signed weight to the symmetric range -WMAX..+WMAX.
  function automatic logic [DW-1:0] clamp_w(input logic [DW-1:0] v);
    if ($signed(v) > POS_LIM)      clamp_w = POS_LIM;
    else if ($signed(v) < NEG_LIM) clamp_w = NEG_LIM;
    else                           clamp_w = v;
  endfunction

  assign wr_value_s = clamp_w(bus.wr_data);
`else
  assign wr_value_s = bus.wr_data;
`endif

  assign rd_oob_s = (bus.rd_addr >= DEPTH_A);
  assign wr_oob_s = (bus.wr_addr >= DEPTH_A);

  // Out-of-range reads return zero instead of whatever the RAM drives.
  assign bus.rd_data   = (rd_valid_r && !rd_oob_r) ? bus.ram_q : '0;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.init_done = init_done_r;

  // Round-robin grant in IDLE; a sweep request blocks both requesters.
  always_comb begin
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    if (state_r == IDLE && !bus.init_start) begin
      if (bus.rd_req && bus.wr_req) begin
        grant_rd_s = !last_rd_r;
        grant_wr_s = last_rd_r;
      end else begin
        grant_rd_s = bus.rd_req;
        grant_wr_s = bus.wr_req;
      end
    end else begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state: a sweep lasts exactly DEPTH cycles.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (bus.init_start) state_nxt_s = INIT;
               else                state_nxt_s = IDLE;
      INIT:    if (count_r == LAST_A) state_nxt_s = IDLE;
               else                   state_nxt_s = INIT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: RAM port driven by the sweep or by the granted requester.
  always_comb begin
    bus.busy     = 1'b0;
    bus.rd_ack   = grant_rd_s;
    bus.wr_ack   = grant_wr_s;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_d    = '0;
    case (state_r)
      INIT: begin
        bus.busy     = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = count_r;
        bus.ram_d    = sext7(lfsr_r);
      end
      IDLE: begin
        if (grant_rd_s) begin
          bus.ram_addr = bus.rd_addr;
        end else if (grant_wr_s) begin
          bus.ram_we   = !wr_oob_s;
          bus.ram_addr = bus.wr_addr;
          bus.ram_d    = wr_value_s;
        end else begin
          bus.ram_addr = '0;
        end
      end
      default: bus.busy = 1'b0;
    endcase
  end

  // Sweep counter, LFSR, arbitration history and read/done pulses.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      count_r     <= '0;
      lfsr_r      <= SEED_EFF;
      last_rd_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_oob_r    <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      rd_valid_r  <= grant_rd_s;
      rd_oob_r    <= grant_rd_s && rd_oob_s;
      init_done_r <= (state_r == INIT) && (count_r == LAST_A);
      if (grant_rd_s || grant_wr_s) last_rd_r <= grant_rd_s;
      else                          last_rd_r <= last_rd_r;
      if (state_r == INIT) begin
        count_r <= count_r + ONE_A;
        lfsr_r  <= lfsr_step(lfsr_r);
      end else if (bus.init_start) begin
        count_r <= '0;
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_weight_ram_sched.sv
// Directed bench for weight_ram_sched with a behavioural 1-cycle-latency RAM.
module tb_weight_ram_sched;
  logic Clock = 1'b0;
  logic Rst;
  always #5 Clock = ~Clock;

  weight_ram_sched_if #(.AW(7), .DW(10)) bus ();
  weight_ram_sched dut (.Clock(Clock), .Rst(Rst), .bus(bus));

  int nvec  = 0;
  int nfail = 0;

`ifdef WRAM_WRITE_CLAMP_EN
  localparam logic [9:0] EXP_P400 = 10'd255;
  localparam logic [9:0] EXP_M300 = 10'h301;
`else
  localparam logic [9:0] EXP_P400 = 10'd190 + 10'd210;
  localparam logic [9:0] EXP_M300 = 10'h2D4;
`endif

  // Single-port RAM; out-of-range reads return a non-zero junk pattern.
  logic [9:0] mem [0:127];
  always @(posedge Clock) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_d;
    bus.ram_q <= (bus.ram_addr < 7'd65) ? mem[bus.ram_addr] : 10'd77;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  int we_cnt, busy_cnt, done_cnt;

  initial begin
    Rst = 1'b1;
    bus.init_start = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = 7'd0;
    bus.wr_req = 1'b0; bus.wr_addr = 7'd0; bus.wr_data = 10'd0;
    @(negedge Clock);
    chk("reset_out", {bus.busy, bus.init_done, bus.rd_valid, bus.rd_ack, bus.wr_ack,
                      bus.ram_we, bus.ram_addr, bus.ram_d}, 32'd0);
    @(negedge Clock);
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("idle_out", {bus.busy, bus.init_done, bus.rd_valid, bus.rd_ack, bus.wr_ack,
                       bus.ram_we, bus.ram_addr, bus.ram_d}, 32'd0);
    end

    // First sweep; a stray init_start inside the sweep must be ignored.
    tick(); bus.init_start = 1'b1;
    @(negedge Clock);
    chk("start_cycle", {bus.busy, bus.ram_we}, 2'b00);
    we_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 75; i++) begin
      tick(); bus.init_start = (i == 10);
      @(negedge Clock);
      we_cnt   += int'(bus.ram_we);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.init_done);
      if (i == 0)  chk("sweep_a0", {bus.ram_we, bus.ram_addr, bus.ram_d}, {1'b1, 7'd0, 10'h3E1});
      if (i == 1)  chk("sweep_a1", {bus.ram_we, bus.ram_addr, bus.ram_d}, {1'b1, 7'd1, 10'h3F0});
      if (i == 64) chk("sweep_last", {bus.ram_we, bus.ram_addr}, {1'b1, 7'd64});
      if (i == 65) chk("sweep_done", {bus.init_done, bus.busy, bus.ram_we}, 3'b100);
    end
    chk("sweep_we_cnt", we_cnt, 65);
    chk("sweep_busy_cnt", busy_cnt, 65);
    chk("sweep_done_cnt", done_cnt, 1);

    // Both requesters held; last grant is write, so read goes first.
    tick(); bus.rd_req = 1'b1; bus.rd_addr = 7'd0;
    bus.wr_req = 1'b1; bus.wr_addr = 7'd5; bus.wr_data = 10'd123;
    @(negedge Clock);
    chk("arb0", {bus.rd_ack, bus.wr_ack, bus.ram_we, bus.ram_addr}, {3'b100, 7'd0});
    tick();
    @(negedge Clock);
    chk("arb1", {bus.rd_ack, bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_d}, {3'b011, 7'd5, 10'd123});
    chk("arb1_rdv", {bus.rd_valid, bus.rd_data}, {1'b1, 10'h3E1});
    tick(); bus.rd_addr = 7'd5; bus.wr_addr = 7'd6; bus.wr_data = 10'h3F6;
    @(negedge Clock);
    chk("arb2", {bus.rd_ack, bus.wr_ack, bus.rd_valid}, 3'b100);
    tick();
    @(negedge Clock);
    chk("arb3", {bus.rd_ack, bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_d}, {3'b011, 7'd6, 10'h3F6});
    chk("arb3_rdv", {bus.rd_valid, bus.rd_data}, {1'b1, 10'd123});

    // Back-to-back reads, one per cycle.
    tick(); bus.wr_req = 1'b0; bus.rd_addr = 7'd1;
    @(negedge Clock);
    chk("b2b0", {bus.rd_ack, bus.wr_ack, bus.ram_addr}, {2'b10, 7'd1});
    tick(); bus.rd_addr = 7'd6;
    @(negedge Clock);
    chk("b2b1", {bus.rd_ack, bus.rd_valid, bus.rd_data}, {2'b11, 10'h3F0});
    tick(); bus.rd_req = 1'b0;
    @(negedge Clock);
    chk("b2b2", {bus.rd_ack, bus.rd_valid, bus.rd_data}, {2'b01, 10'h3F6});
    tick();
    @(negedge Clock);
    chk("b2b3", bus.rd_valid, 1'b0);

    // Out-of-range write dropped, out-of-range read returns zero.
    tick(); bus.wr_req = 1'b1; bus.wr_addr = 7'd70; bus.wr_data = 10'd100;
    @(negedge Clock);
    chk("oob_wr", {bus.wr_ack, bus.ram_we}, 2'b10);
    tick(); bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 7'd70;
    @(negedge Clock);
    chk("oob_rd_ack", bus.rd_ack, 1'b1);
    tick(); bus.rd_req = 1'b0;
    @(negedge Clock);
    chk("oob_rd", {bus.rd_valid, bus.rd_data}, {1'b1, 10'd0});

    // Write data passes through or saturates depending on the build.
    tick(); bus.wr_req = 1'b1; bus.wr_addr = 7'd3; bus.wr_data = 10'd400;
    @(negedge Clock);
    chk("wr_p400", {bus.wr_ack, bus.ram_we, bus.ram_d}, {2'b11, EXP_P400});
    tick(); bus.wr_data = 10'h2D4;
    @(negedge Clock);
    chk("wr_m300", {bus.wr_ack, bus.ram_we, bus.ram_d}, {2'b11, EXP_M300});
    tick(); bus.wr_req = 1'b0;

    // Read acked just before init_start still completes; init_start wins.
    bus.rd_req = 1'b1; bus.rd_addr = 7'd1;
    @(negedge Clock);
    chk("pre_init_rd", bus.rd_ack, 1'b1);
    tick(); bus.rd_addr = 7'd0; bus.init_start = 1'b1;
    @(negedge Clock);
    chk("prio", {bus.rd_ack, bus.wr_ack, bus.rd_valid, bus.rd_data, bus.busy}, {3'b001, 10'h3F0, 1'b0});
    tick(); bus.init_start = 1'b0; bus.rd_req = 1'b0;
    @(negedge Clock);
    chk("init2_busy", {bus.busy, bus.rd_valid, bus.rd_ack}, 3'b100);
    done_cnt = 0;
    for (int j = 1; j <= 30; j++) begin
      tick();
      @(negedge Clock);
      done_cnt += int'(bus.init_done);
      if (j == 30) chk("mid_addr", {bus.ram_we, bus.ram_addr}, {1'b1, 7'd30});
    end

    // Reset in the middle of the sweep.
    Rst = 1'b1;
    #1;
    chk("rst_mid", {bus.busy, bus.init_done, bus.ram_we, bus.rd_valid}, 4'b0000);
    tick(); tick();
    @(negedge Clock);
    Rst = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      @(negedge Clock);
      done_cnt += int'(bus.init_done);
      busy_cnt += int'(bus.busy);
    end
    chk("no_done_after_rst", done_cnt, 0);
    chk("no_busy_after_rst", busy_cnt, 0);

    // New sweep restarts from the seed.
    tick(); bus.init_start = 1'b1;
    @(negedge Clock);
    tick(); bus.init_start = 1'b0;
    @(negedge Clock);
    chk("resweep_a0", {bus.ram_we, bus.ram_addr, bus.ram_d}, {1'b1, 7'd0, 10'h3E1});
    tick();
    @(negedge Clock);
    chk("resweep_a1", {bus.ram_we, bus.ram_addr, bus.ram_d}, {1'b1, 7'd1, 10'h3F0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/weight_ram_sched.md
Name: weight_ram_sched

Overview:
Controller and arbiter in front of the single-port weight RAM (DEPTH x DW, synchronous read, 1-cycle latency, WE=1 write / WE=0 read).
- Runs a pseudo-random weight initialisation sweep on request.
- Between sweeps, shares the RAM port between a read requester (forward pass) and a write requester (weight update) using round-robin.

Parameters:
DEPTH, 65, number of weight entries (valid addresses 0..DEPTH-1)
AW, 7, address width
DW, 10, weight width (signed two's complement)
SEED, 16'hACE1, LFSR reset value; if 0, 16'h0001 is used instead
WMAX, 255, clamp magnitude for the optional feature

Ports:
Clock  in  1  system clock, rising edge
Rst  in  1  asynchronous active-high reset
init_start  in  1  one-cycle pulse: start randomisation sweep
busy  out  1  high while sweep in progress
init_done  out  1  one-cycle pulse when sweep completes
rd_req  in  1  read request
rd_addr  in  AW  read address
rd_ack  out  1  read granted this cycle
rd_valid  out  1  rd_data valid (one cycle after rd_ack)
rd_data  out  DW  signed read data
wr_req  in  1  write request
wr_addr  in  AW  write address
wr_data  in  DW  signed write data
wr_ack  out  1  write granted (RAM written at this cycle's edge)
ram_addr  out  AW  to RAM Address
ram_d  out  DW  to RAM D
ram_we  out  1  to RAM WE
ram_q  in  DW  from RAM Q

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE, counter=0, LFSR=SEED, last-grant=write.
  - busy=0, init_done=0, rd_valid=0, rd_ack=0, wr_ack=0, ram_we=0, ram_addr=0, ram_d=0.
- States: IDLE and INIT.
- IDLE:
  - init_start=1 -> INIT next cycle, counter=0.
  - init_start has priority over rd_req/wr_req in the same cycle; neither is acked that cycle.
- IDLE arbitration (combinational ack, same cycle as request):
  - Only rd_req -> grant read.
  - Only wr_req -> grant write.
  - Both -> grant the one not granted last; last-grant updates on every grant.
  - Requesters hold req/addr/data until ack.
- Read grant:
  - ram_we=0, ram_addr=rd_addr, rd_ack=1.
  - Next cycle: rd_valid=1, rd_data=ram_q.
  - rd_valid is a registered 1-cycle pulse; back-to-back reads give 1 read per cycle.
- Write grant:
  - ram_we=1, ram_addr=wr_addr, ram_d=wr_data, wr_ack=1.
- Address out of range (addr >= DEPTH):
  - Still acked.
  - Write: ram_we forced 0 (dropped).
  - Read: rd_valid next cycle with rd_data=0.
- INIT:
  - busy=1; rd_ack=wr_ack=0; requests wait.
  - Each cycle: ram_we=1, ram_addr=counter, ram_d = sign-extended LFSR[6:0] (range -64..63); then counter+1 and LFSR advances.
  - LFSR: 16-bit Galois, right shift; if lsb=1, XOR 16'hB400.
  - After the write at counter=DEPTH-1: state -> IDLE, busy=0 and init_done=1 for exactly one cycle.
  - Sweep takes exactly DEPTH cycles.
  - init_start during INIT is ignored.
- LFSR is reloaded only by reset, so consecutive sweeps produce different weights.
- Reset mid-INIT:
  - Immediate return to reset values; no init_done.
  - Partially written entries are left as-is.
- A read acked in the cycle before entering INIT still delivers rd_valid in the next cycle.

Optional Feature:
WRAM_WRITE_CLAMP_EN
- Defined: on a write grant, ram_d = saturate(wr_data, -WMAX, +WMAX). Init sweep data is unaffected.
- Undefined: wr_data passes unmodified. No clamp logic is present.

Test Plan:
- Rst pulse, then idle 5 cycles -> all outputs 0; no RAM write (ram_we=0).
- init_start with SEED=16'hACE1 -> writes addr 0 = -31 (0x61) and addr 1 = -16 (0x70); 65 consecutive ram_we cycles; init_done pulses once, the cycle after the addr-64 write; busy high for exactly 65 cycles.
- rd_req and wr_req held continuously in IDLE, last grant = write -> acks alternate rd, wr, rd, wr…; each rd_ack followed next cycle by rd_valid carrying the RAM value.
- wr_req addr=70, data=100 -> wr_ack=1, ram_we=0. rd_req addr=70 -> rd_valid next cycle, rd_data=0.
- Rst asserted at counter=30 of a sweep -> busy=0 immediately; init_done never pulses; the next sweep starts again from the SEED-derived values (-31 at addr 0).
- With WRAM_WRITE_CLAMP_EN: wr_data=400 -> ram_d=255; wr_data=-300 -> ram_d=-255. Without the macro: ram_d=400 and -300.
